light_conflict_monitor: RTL and testbench
=========================================

LIGHT_CONFLICT_MONITOR -- requirements
Module: light_conflict_monitor

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  MIN_YLW    3   minimum consecutive yellow cycles before red
  MIN_RED    2   minimum consecutive all-red cycles before either light goes green
  DARK_MAX   4   maximum consecutive cycles a light may show 000
  FLASH_HALF 8   flash half-period in cycles
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk        in   1  clock; all logic on posedge
  reset_n    in   1  reset, asynchronous, active-high
  light0     in   3  lamp word {red,ylw,grn} of light 0
  light1     in   3  lamp word {red,ylw,grn} of light 1
  fault_clr  in   1  operator clear request, level-sampled
  fault      out  1  latched fault flag
  fault_code out  3  code of first detected fault, 0 = none
  flash_red  out  1  failsafe flashing-red override drive
Reset: reset_n, asynchronous, active-high; clock clk.

Function
REQ-003 Lamp words SHALL be sampled every clk edge; each light keeps a registered previous word.
REQ-004 Legal words SHALL be 100, 010, 001 and 000 (dark); any other word (including 111) SHALL be an illegal lamp word.
REQ-005 Fault codes: 1 conflict (both lights non-red and non-dark in the same sample), 2 illegal lamp word, 3 dark longer than DARK_MAX consecutive cycles, 4 short yellow (yellow->red with yellow count < MIN_YLW), 5 illegal transition (grn->red, ylw->grn, red->ylw), 6 short clearance (red->grn while all-red count < MIN_RED).
REQ-006 Transitions out of dark SHALL be legal to any word; dark SHALL not count as red for the clearance counter.
REQ-007 Yellow counter per light: counts consecutive yellow samples, saturates at 255, clears on any non-yellow sample.
REQ-008 All-red counter: counts consecutive samples with both words 100, saturates at 255, clears otherwise.
REQ-009 Detection latency: fault and fault_code SHALL update at the first clk edge at which the offending word is on the inputs.
REQ-010 Simultaneous faults: the lowest code SHALL be latched.
REQ-011 FSM states: MON, FLASH, ARM.
REQ-012 MON: fault=0, flash_red=0, fault_code=0; any fault -> FLASH, latching the code.
REQ-013 FLASH: fault=1; flash_red starts at 1 and toggles every FLASH_HALF cycles; no new faults latched; fault_clr=1 -> ARM.
REQ-014 ARM: fault=1, flash_red continues; faults ignored; after MIN_RED consecutive samples with both lights 100 or both 000 -> MON, fault_code cleared, all counters cleared; on leaving ARM, flash_red=0.
REQ-015 fault_clr SHALL be ignored in MON and ARM.

Reset
REQ-016 While reset_n=1: state=MON, fault=0, fault_code=0, flash_red=0, previous words=000, all counters=0; release is synchronous to the next clk edge.
REQ-017 Reset mid-FLASH or mid-ARM SHALL abandon the fault immediately; the outputs then follow REQ-016.

Structure
REQ-018 Package traffic_pkg SHALL hold the lamp masks (RED/YLW/GRN/ALL_OFF/ERR), the fault code constants and the FSM state encoding.
REQ-019 Sub-module lamp_phase_tracker, instantiated once per light, SHALL hold the previous word, the yellow counter, the dark counter, and the illegal-word, transition and short-yellow flags.

Verification
REQ-020 Legal cycle: grn 20, ylw 3, red-red 2, swap, repeated 3 times -> fault stays 0 and fault_code stays 0 throughout.
REQ-021 light0=001 and light1=001 on the same edge -> fault=1 and fault_code=1 at that edge; flash_red=1 for 8 cycles, then 0 for 8.
REQ-022 light0 yellow for 2 cycles, then red -> fault_code=4; separately, grn->red directly -> fault_code=5; light0=111 together with a conflict -> fault_code=1.
REQ-023 All-red for 1 cycle, then light1 100->001 -> fault_code=6; then fault_clr=1 with both lights 100 for 2 cycles -> MON, fault=0, fault_code=0.
REQ-024 light0 held 000 for 5 cycles -> fault_code=3 on the 5th edge; 4 cycles dark -> no fault.
REQ-025 reset_n pulsed high asynchronously during FLASH -> fault=0, flash_red=0 without waiting for a clk edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes, monitor state encoding and small helpers
// for the two-light conflict monitor.
package traffic_pkg;

    // Width of every run-length counter; all counters saturate at CNT_MAX.
    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    // Lamp words are {red, ylw, grn}.
    localparam logic [2:0] LAMP_RED     = 3'b100;
    localparam logic [2:0] LAMP_YLW     = 3'b010;
    localparam logic [2:0] LAMP_GRN     = 3'b001;
    localparam logic [2:0] LAMP_ALL_OFF = 3'b000;
    localparam logic [2:0] LAMP_ERR     = 3'b111;

    // Fault codes; a lower code wins when several faults hit the same sample.
    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_CONFLICT  = 3'd1;
    localparam logic [2:0] FC_ILLEGAL   = 3'd2;
    localparam logic [2:0] FC_DARK      = 3'd3;
    localparam logic [2:0] FC_SHORT_YLW = 3'd4;
    localparam logic [2:0] FC_BAD_TRANS = 3'd5;
    localparam logic [2:0] FC_SHORT_CLR = 3'd6;

    // Monitor FSM: watching, latched fault with flashing red, waiting to re-arm.
    typedef enum logic [1:0] {
        ST_MON   = 2'd0,
        ST_FLASH = 2'd1,
        ST_ARM   = 2'd2
    } mon_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 8'd1;
    endfunction

    function automatic logic lamp_legal(input logic [2:0] w);
        return (w == LAMP_RED) || (w == LAMP_YLW) || (w == LAMP_GRN) || (w == LAMP_ALL_OFF);
    endfunction

    // A lamp "shows traffic" when it is neither red nor dark; illegal words count too.
    function automatic logic lamp_active(input logic [2:0] w);
        return (w != LAMP_RED) && (w != LAMP_ALL_OFF);
    endfunction

endpackage

// File: rtl/lamp_phase_tracker.sv
// Per-light history: previous lamp word, consecutive-yellow and consecutive-dark
// run lengths, and the per-light fault flags derived from the word now on the input.
module lamp_phase_tracker
    import traffic_pkg::*;
#(
    parameter int MIN_YLW  = 3,
    parameter int DARK_MAX = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cnt_clr,
    input  logic [2:0] word,
    output logic       illegal_word,
    output logic       bad_trans,
    output logic       short_ylw,
    output logic       dark_long,
    output logic       red_to_grn
);

    localparam logic [CNT_W-1:0] MIN_YLW_C  = CNT_W'(MIN_YLW);
    localparam logic [CNT_W-1:0] DARK_MAX_C = CNT_W'(DARK_MAX);

    logic [2:0]       prev_q, prev_d;
    logic [CNT_W-1:0] ylw_cnt_q, ylw_cnt_d;
    logic [CNT_W-1:0] dark_cnt_q, dark_cnt_d;

    // Next history: always remember the word; runs extend or restart, and a re-arm wipes them.
    always_comb begin
        prev_d     = word;
        ylw_cnt_d  = (word == LAMP_YLW)     ? sat_inc(ylw_cnt_q)  : '0;
        dark_cnt_d = (word == LAMP_ALL_OFF) ? sat_inc(dark_cnt_q) : '0;
        if (cnt_clr) begin
            ylw_cnt_d  = '0;
            dark_cnt_d = '0;
        end
    end

    // History registers; reset leaves the light looking dark with empty runs.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            prev_q     <= LAMP_ALL_OFF;
            ylw_cnt_q  <= '0;
            dark_cnt_q <= '0;
        end else begin
            prev_q     <= prev_d;
            ylw_cnt_q  <= ylw_cnt_d;
            dark_cnt_q <= dark_cnt_d;
        end
    end

    // Flags judge the incoming word against the history up to the previous sample.
    always_comb begin
        illegal_word = !lamp_legal(word);
        bad_trans    = ((prev_q == LAMP_GRN) && (word == LAMP_RED))
                    || ((prev_q == LAMP_YLW) && (word == LAMP_GRN))
                    || ((prev_q == LAMP_RED) && (word == LAMP_YLW));
        short_ylw    = (prev_q == LAMP_YLW) && (word == LAMP_RED) && (ylw_cnt_q < MIN_YLW_C);
        // The incoming dark sample is the (dark_cnt_q+1)-th in a row.
        dark_long    = (word == LAMP_ALL_OFF) && (dark_cnt_q >= DARK_MAX_C);
        red_to_grn   = (prev_q == LAMP_RED) && (word == LAMP_GRN);
    end

endmodule

// File: rtl/light_conflict_monitor.sv
// Two-light conflict monitor: detects unsafe lamp patterns in the cycle they appear,
// latches the first fault code, drives a flashing-red failsafe, and re-arms after an
// operator clear followed by a settled all-red (or all-dark) interval.
module light_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YLW    = 3,
    parameter int MIN_RED    = 2,
    parameter int DARK_MAX   = 4,
    parameter int FLASH_HALF = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] light0,
    input  logic [2:0] light1,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_red
);

    localparam logic [CNT_W-1:0] MIN_RED_C  = CNT_W'(MIN_RED);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

    mon_state_e       state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic             flash_q, flash_d;
    logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
    logic [CNT_W-1:0] allred_cnt_q, allred_cnt_d;
    logic [CNT_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [CNT_W-1:0] arm_cnt_inc;

    logic illegal0, bad_trans0, short_ylw0, dark_long0, r2g0;
    logic illegal1, bad_trans1, short_ylw1, dark_long1, r2g1;
    logic both_red, both_dark, arm_qual, conflict, short_clr;
    logic [2:0] fault_sel;
    logic fault_det, enter_flash, leave_arm;

    lamp_phase_tracker #(.MIN_YLW(MIN_YLW), .DARK_MAX(DARK_MAX)) u_trk0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .cnt_clr      (leave_arm),
        .word         (light0),
        .illegal_word (illegal0),
        .bad_trans    (bad_trans0),
        .short_ylw    (short_ylw0),
        .dark_long    (dark_long0),
        .red_to_grn   (r2g0)
    );

    lamp_phase_tracker #(.MIN_YLW(MIN_YLW), .DARK_MAX(DARK_MAX)) u_trk1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .cnt_clr      (leave_arm),
        .word         (light1),
        .illegal_word (illegal1),
        .bad_trans    (bad_trans1),
        .short_ylw    (short_ylw1),
        .dark_long    (dark_long1),
        .red_to_grn   (r2g1)
    );

    // Combine both lights into a single prioritised fault code (lowest code wins).
    always_comb begin
        both_red  = (light0 == LAMP_RED) && (light1 == LAMP_RED);
        both_dark = (light0 == LAMP_ALL_OFF) && (light1 == LAMP_ALL_OFF);
        arm_qual  = both_red || both_dark;
        conflict  = lamp_active(light0) && lamp_active(light1);
        short_clr = (r2g0 || r2g1) && (allred_cnt_q < MIN_RED_C);
        fault_sel = FC_NONE;
        if (conflict)                       fault_sel = FC_CONFLICT;
        else if (illegal0 || illegal1)      fault_sel = FC_ILLEGAL;
        else if (dark_long0 || dark_long1)  fault_sel = FC_DARK;
        else if (short_ylw0 || short_ylw1)  fault_sel = FC_SHORT_YLW;
        else if (bad_trans0 || bad_trans1)  fault_sel = FC_BAD_TRANS;
        else if (short_clr)                 fault_sel = FC_SHORT_CLR;
        fault_det   = (fault_sel != FC_NONE);
        arm_cnt_inc = sat_inc(arm_cnt_q);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) state_q <= ST_MON;
        else         state_q <= state_d;
    end

    // FSM next state: only MON listens for faults, only FLASH listens for the clear.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MON:   if (fault_det) state_d = ST_FLASH;
            ST_FLASH: if (fault_clr) state_d = ST_ARM;
            ST_ARM:   if (arm_qual && (arm_cnt_inc >= MIN_RED_C)) state_d = ST_MON;
            default:  state_d = ST_MON;
        endcase
        enter_flash = (state_q == ST_MON) && (state_d == ST_FLASH);
        leave_arm   = (state_q == ST_ARM) && (state_d == ST_MON);
    end

    // Latched code, flash phase, all-red run and re-arm run for the next cycle.
    always_comb begin
        code_d       = code_q;
        flash_d      = flash_q;
        flash_cnt_d  = flash_cnt_q;
        allred_cnt_d = both_red ? sat_inc(allred_cnt_q) : '0;
        arm_cnt_d    = '0;
        if (state_q == ST_ARM) arm_cnt_d = arm_qual ? arm_cnt_inc : '0;
        if (enter_flash) begin
            code_d      = fault_sel;
            flash_d     = 1'b1;
            flash_cnt_d = '0;
        end else if (leave_arm) begin
            code_d       = FC_NONE;
            flash_d      = 1'b0;
            flash_cnt_d  = '0;
            allred_cnt_d = '0;
            arm_cnt_d    = '0;
        end else if (state_q != ST_MON) begin
            if (flash_cnt_q == FLASH_LAST) begin
                flash_d     = !flash_q;
                flash_cnt_d = '0;
            end else begin
                flash_cnt_d = flash_cnt_q + 8'd1;
            end
        end
    end

    // Datapath registers; reset drops any latched fault immediately.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            code_q       <= FC_NONE;
            flash_q      <= 1'b0;
            flash_cnt_q  <= '0;
            allred_cnt_q <= '0;
            arm_cnt_q    <= '0;
        end else begin
            code_q       <= code_d;
            flash_q      <= flash_d;
            flash_cnt_q  <= flash_cnt_d;
            allred_cnt_q <= allred_cnt_d;
            arm_cnt_q    <= arm_cnt_d;
        end
    end

    // FSM outputs: fault follows the state, code and flash come from their registers.
    always_comb begin
        fault      = (state_q != ST_MON);
        fault_code = code_q;
        flash_red  = flash_q;
    end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Scoreboard bench for light_conflict_monitor: a driver applies lamp words at the
// falling edge and pushes the reference model's expected {fault, code, flash} into a
// queue; a monitor pops and compares one entry after every rising edge.
module tb_light_conflict_monitor;

  localparam int MIN_YLW    = 3;
  localparam int MIN_RED    = 2;
  localparam int DARK_MAX   = 4;
  localparam int FLASH_HALF = 8;

  localparam logic [2:0] W_RED = 3'b100;
  localparam logic [2:0] W_YLW = 3'b010;
  localparam logic [2:0] W_GRN = 3'b001;
  localparam logic [2:0] W_OFF = 3'b000;
  localparam logic [2:0] W_ALL = 3'b111;

  logic       clk;
  logic       reset_n;
  logic [2:0] light0;
  logic [2:0] light1;
  logic       fault_clr;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_red;

  int n_cmp;
  int n_bad;

  logic [4:0] exp_q[$];
  string      tag_q[$];
  string      cur_tag;

  // Reference model: mode 0 watching, 1 fault flashing, 2 waiting to re-arm.
  int         m_mode;
  logic [2:0] m_code;
  int         m_age;
  int         m_arm_run;
  logic [2:0] m_prev0;
  logic [2:0] m_prev1;
  logic [5:0] m_hist[$];

  light_conflict_monitor #(
    .MIN_YLW(MIN_YLW), .MIN_RED(MIN_RED), .DARK_MAX(DARK_MAX), .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .light0     (light0),
    .light1     (light1),
    .fault_clr  (fault_clr),
    .fault      (fault),
    .fault_code (fault_code),
    .flash_red  (flash_red)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit legal(input logic [2:0] w);
    return (w == W_RED) || (w == W_YLW) || (w == W_GRN) || (w == W_OFF);
  endfunction

  function automatic bit active(input logic [2:0] w);
    return (w != W_RED) && (w != W_OFF);
  endfunction

  function automatic bit bad_pair(input logic [2:0] p, input logic [2:0] w);
    return (p == W_GRN && w == W_RED) || (p == W_YLW && w == W_GRN) || (p == W_RED && w == W_YLW);
  endfunction

  // Length of the trailing run in the recorded samples: light 0, light 1, or both (which=2).
  function automatic int trail(input int which, input logic [2:0] w);
    int n;
    n = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      logic [5:0] h;
      bit hit;
      h = m_hist[i];
      if (which == 0)      hit = (h[5:3] == w);
      else if (which == 1) hit = (h[2:0] == w);
      else                 hit = (h[5:3] == w) && (h[2:0] == w);
      if (!hit) break;
      n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_code = 3'd0; m_age = 0; m_arm_run = 0;
    m_prev0 = W_OFF; m_prev1 = W_OFF;
    m_hist.delete();
  endtask

  task automatic model_step(input logic [2:0] w0, input logic [2:0] w1, input logic clr,
                            output logic [4:0] e);
    logic [6:1] f;
    int c;
    bit leave;
    bit flash;
    leave = 0;
    f[1] = active(w0) && active(w1);
    f[2] = !legal(w0) || !legal(w1);
    f[3] = (w0 == W_OFF && trail(0, W_OFF) >= DARK_MAX) || (w1 == W_OFF && trail(1, W_OFF) >= DARK_MAX);
    f[4] = (m_prev0 == W_YLW && w0 == W_RED && trail(0, W_YLW) < MIN_YLW)
        || (m_prev1 == W_YLW && w1 == W_RED && trail(1, W_YLW) < MIN_YLW);
    f[5] = bad_pair(m_prev0, w0) || bad_pair(m_prev1, w1);
    f[6] = ((m_prev0 == W_RED && w0 == W_GRN) || (m_prev1 == W_RED && w1 == W_GRN))
        && (trail(2, W_RED) < MIN_RED);
    c = 0;
    for (int k = 6; k >= 1; k--) if (f[k]) c = k;
    case (m_mode)
      0: if (c != 0) begin m_mode = 1; m_code = 3'(c); m_age = 0; end
      1: begin
        m_age++;
        if (clr) begin m_mode = 2; m_arm_run = 0; end
      end
      default: begin
        m_age++;
        if ((w0 == W_RED && w1 == W_RED) || (w0 == W_OFF && w1 == W_OFF)) m_arm_run++;
        else m_arm_run = 0;
        if (m_arm_run >= MIN_RED) begin m_mode = 0; m_code = 3'd0; leave = 1; end
      end
    endcase
    if (leave) m_hist.delete();
    else begin
      m_hist.push_back({w0, w1});
      if (m_hist.size() > 300) void'(m_hist.pop_front());
    end
    m_prev0 = w0; m_prev1 = w1;
    flash = (m_mode != 0) && (((m_age / FLASH_HALF) % 2) == 0);
    e = {(m_mode != 0), m_code, flash};
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; applies one sample and returns at the next falling edge.
  task automatic drive(input logic [2:0] w0, input logic [2:0] w1, input logic clr);
    logic [4:0] e;
    light0 = w0; light1 = w1; fault_clr = clr;
    model_step(w0, w1, clr, e);
    exp_q.push_back(e);
    tag_q.push_back(cur_tag);
    @(negedge clk);
  endtask

  task automatic check_now(input string name, input logic [4:0] want);
    n_cmp++;
    if ({fault, fault_code, flash_red} !== want) begin
      n_bad++;
      $display("FAIL %s: got fault=%0b code=%0d flash=%0b, want fault=%0b code=%0d flash=%0b",
               name, fault, fault_code, flash_red, want[4], want[3:1], want[0]);
    end
  endtask

  // Asserts reset between clock edges, checks outputs clear at once, then releases.
  task automatic do_reset(input string name);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    check_now(name, 5'b0);
    light0 = W_RED; light1 = W_RED; fault_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_now({name, "_held"}, 5'b0);
    reset_n = 1'b0;
    model_reset();
  endtask

  task automatic legal_cycle(input int g, input int y, input int r);
    repeat (g) drive(W_GRN, W_RED, 1'b0);
    repeat (y) drive(W_YLW, W_RED, 1'b0);
    repeat (r) drive(W_RED, W_RED, 1'b0);
    repeat (g) drive(W_RED, W_GRN, 1'b0);
    repeat (y) drive(W_RED, W_YLW, 1'b0);
    repeat (r) drive(W_RED, W_RED, 1'b0);
  endtask

  function automatic logic [2:0] pick_word();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 3) return W_RED;
    if (r == 4) return W_YLW;
    if (r == 5 || r == 7) return W_GRN;
    if (r == 6) return W_OFF;
    if (r == 8) return W_ALL;
    return 3'($urandom_range(0, 7));
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [4:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_now(t, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_bad = 0;
    cur_tag = "reset";
    light0 = W_OFF; light1 = W_OFF; fault_clr = 1'b0;
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_now("reset_state", 5'b0);
    reset_n = 1'b0;

    cur_tag = "legal_cycle";
    repeat (3) legal_cycle(20, 3, 2);
    cur_tag = "legal_cycle_rand";
    repeat (2) legal_cycle($urandom_range(20, 24), $urandom_range(3, 5), $urandom_range(2, 4));

    do_reset("reset_a");
    cur_tag = "conflict_flash";
    drive(W_GRN, W_GRN, 1'b0);
    repeat (19) drive(W_GRN, 3'($urandom_range(0, 7)), 1'b0);
    do_reset("async_reset_in_flash");

    cur_tag = "short_yellow";
    repeat (3) drive(W_GRN, W_RED, 1'b0);
    repeat (2) drive(W_YLW, W_RED, 1'b0);
    repeat (4) drive(W_RED, W_RED, 1'b0);
    do_reset("reset_b");

    cur_tag = "grn_to_red";
    repeat (3) drive(W_GRN, W_RED, 1'b0);
    repeat (3) drive(W_RED, W_RED, 1'b0);
    do_reset("reset_c");

    cur_tag = "illegal_with_conflict";
    repeat (2) drive(W_GRN, W_RED, 1'b0);
    repeat (3) drive(W_ALL, W_GRN, 1'b0);
    do_reset("reset_d");

    cur_tag = "illegal_word";
    drive(W_RED, W_RED, 1'b0);
    repeat (3) drive(3'b110, W_RED, 1'b0);
    do_reset("reset_e");

    cur_tag = "short_clearance";
    repeat (3) drive(W_GRN, W_RED, 1'b0);
    repeat (3) drive(W_YLW, W_RED, 1'b0);
    drive(W_RED, W_RED, 1'b0);
    repeat (4) drive(W_RED, W_GRN, 1'b0);
    cur_tag = "clear_and_rearm";
    repeat (3) drive(W_RED, W_RED, 1'b1);
    repeat (3) drive(W_RED, W_RED, 1'b0);
    cur_tag = "after_rearm";
    repeat (5) drive(W_GRN, W_RED, 1'b0);
    do_reset("reset_f");

    cur_tag = "dark_4";
    repeat (4) drive(W_OFF, W_RED, 1'b0);
    repeat (3) drive(W_GRN, W_RED, 1'b0);
    cur_tag = "dark_5";
    repeat (5) drive(W_OFF, W_RED, 1'b0);
    repeat (3) drive(W_OFF, W_RED, 1'b0);
    do_reset("reset_g");

    cur_tag = "random";
    for (int s = 0; s < 80; s++) begin
      logic [2:0] a;
      logic [2:0] b;
      int len;
      logic clr;
      a = pick_word();
      b = pick_word();
      if ($urandom_range(0, 3) == 0) begin a = W_RED; b = W_RED; end
      len = $urandom_range(1, 6);
      clr = ($urandom_range(0, 3) == 0);
      repeat (len) drive(a, b, clr);
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
